// File: rtl/regfile_mp_param.sv
// rtl/regfile_mp_param.sv - dual-write multi-read register file with pending scoreboard and sweep clear
//
// Purpose: DEPTH x DATA_W register file with two write ports (B beats A on an
// address clash), N_RD combinational read ports with optional same-cycle
// write forwarding, a per-register busy scoreboard, and a sweep engine that
// zeroes every register and busy bit over DEPTH cycles.
//
// Ports:
//   clock, async_reset          rising-edge clock, asynchronous active-low reset
//   we_a/waddr_a/wdata_a        write port A
//   we_b/waddr_b/wdata_b        write port B (wins over A on the same address)
//   raddr / rdata               packed read ports, port i at [i*AW +: AW] / [i*DATA_W +: DATA_W]
//   busy_set/busy_addr/busy     scoreboard mark input and per-register pending bits
//   clear_req                   starts a sweep clear (accepted only when idle)
//   clear_busy / clear_done     high during the sweep / one-cycle completion pulse

module regfile_mp_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   async_reset,
  input  logic                   we_a,
  input  logic [AW-1:0]          waddr_a,
  input  logic [DATA_W-1:0]      wdata_a,
  input  logic                   we_b,
  input  logic [AW-1:0]          waddr_b,
  input  logic [DATA_W-1:0]      wdata_b,
  input  logic [N_RD*AW-1:0]     raddr,
  output logic [N_RD*DATA_W-1:0] rdata,
  input  logic                   busy_set,
  input  logic [AW-1:0]          busy_addr,
  output logic [DEPTH-1:0]       busy,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [AW-1:0]            r_idx;
  logic [AW-1:0]            w_idx_nxt;
  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         r_busy;
  logic [DEPTH-1:0]         w_busy_nxt;
  logic                     w_idle;
  logic                     w_we_a;
  logic                     w_we_b;
  logic [AW-1:0]            w_ra;
  logic [DATA_W-1:0]        w_val;
  logic [N_RD*DATA_W-1:0]   w_rdata;

  // User writes only land while idle; a hardwired-zero register 0 simply
  // never sees an enabled write, so it needs no special storage handling.
  assign w_idle = (r_state == ST_IDLE);
  assign w_we_a = w_idle && we_a && !((ZERO_REG != 0) && (waddr_a == '0));
  assign w_we_b = w_idle && we_b && !((ZERO_REG != 0) && (waddr_b == '0));

  // Sweep FSM: next-state and outputs
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    clear_busy  = 1'b0;
    clear_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_nxt = ST_SWEEP;
          w_idx_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        clear_busy = 1'b1;
        // AW-bit add wraps to 0 after DEPTH-1
        w_idx_nxt  = r_idx + AW'(1);
        if (r_idx == AW'(DEPTH - 1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        clear_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Storage: port B is written after port A so it wins on an address clash
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == ST_SWEEP) begin
      r_mem[r_idx] <= '0;
    end else begin
      if (w_we_a) r_mem[waddr_a] <= wdata_a;
      if (w_we_b) r_mem[waddr_b] <= wdata_b;
    end
  end

  // Scoreboard: write completions clear, then a new issue sets (set wins)
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_state == ST_SWEEP) begin
      w_busy_nxt[r_idx] = 1'b0;
    end else if (w_idle) begin
      if (w_we_a)   w_busy_nxt[waddr_a]   = 1'b0;
      if (w_we_b)   w_busy_nxt[waddr_b]   = 1'b0;
      if (busy_set) w_busy_nxt[busy_addr] = 1'b1;
    end
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy = r_busy;

  // Read ports: stored value, overridden by a same-cycle write when
  // forwarding is enabled (B checked last so it wins), then zero-register mask
  always_comb begin
    w_rdata = '0;
    w_ra    = '0;
    w_val   = '0;
    for (int i = 0; i < N_RD; i++) begin
      w_ra  = raddr[i*AW +: AW];
      w_val = r_mem[w_ra];
      if ((BYPASS != 0) && w_we_a && (waddr_a == w_ra)) w_val = wdata_a;
      if ((BYPASS != 0) && w_we_b && (waddr_b == w_ra)) w_val = wdata_b;
      if ((ZERO_REG != 0) && (w_ra == '0)) w_val = '0;
      w_rdata[i*DATA_W +: DATA_W] = w_val;
    end
  end

  assign rdata = w_rdata;

endmodule

// File: tb/tb_regfile_mp_param.sv
// tb/tb_regfile_mp_param.sv - scoreboard bench over three configurations of regfile_mp_param

module tb_regfile_mp_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        async_reset;
  logic        we_a, we_b, busy_set, clear_req;
  logic [4:0]  waddr_a, waddr_b, busy_addr;
  logic [63:0] wdata_a, wdata_b;
  logic [4:0]  ra0, ra1, ra2;

  logic [63:0]  rd_0;
  logic [31:0]  busy_0;
  logic         cb_0, cd_0;
  logic [191:0] rd_1;
  logic [15:0]  busy_1;
  logic         cb_1, cd_1;
  logic [63:0]  rd_2;
  logic [31:0]  busy_2;
  logic         cb_2, cd_2;

  // dut0: defaults; dut1: 64-bit/16 deep/3 reads/ordinary reg 0; dut2: defaults without forwarding
  regfile_mp_param #(.DATA_W(32), .DEPTH(32), .N_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clock(clock), .async_reset(async_reset),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a[31:0]),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b[31:0]),
    .raddr({ra1, ra0}), .rdata(rd_0),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy_0),
    .clear_req(clear_req), .clear_busy(cb_0), .clear_done(cd_0));

  regfile_mp_param #(.DATA_W(64), .DEPTH(16), .N_RD(3), .ZERO_REG(0), .BYPASS(1)) u_dut1 (
    .clock(clock), .async_reset(async_reset),
    .we_a(we_a), .waddr_a(waddr_a[3:0]), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b[3:0]), .wdata_b(wdata_b),
    .raddr({ra2[3:0], ra1[3:0], ra0[3:0]}), .rdata(rd_1),
    .busy_set(busy_set), .busy_addr(busy_addr[3:0]), .busy(busy_1),
    .clear_req(clear_req), .clear_busy(cb_1), .clear_done(cd_1));

  regfile_mp_param #(.DATA_W(32), .DEPTH(32), .N_RD(2), .ZERO_REG(1), .BYPASS(0)) u_dut2 (
    .clock(clock), .async_reset(async_reset),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a[31:0]),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b[31:0]),
    .raddr({ra1, ra0}), .rdata(rd_2),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy_2),
    .clear_req(clear_req), .clear_busy(cb_2), .clear_done(cd_2));

  int cfg_dw    [3] = '{32, 64, 32};
  int cfg_depth [3] = '{32, 16, 32};
  int cfg_nrd   [3] = '{2, 3, 2};
  int cfg_zr    [3] = '{1, 0, 1};
  int cfg_byp   [3] = '{1, 1, 0};

  // Reference model: register contents, pending flags, and sweep progress
  // (0 = idle, 1 = sweeping, 2 = completion cycle)
  logic [63:0] m_mem   [3][32];
  logic        m_busy  [3][32];
  int          m_phase [3];
  int          m_idx   [3];

  typedef struct {
    int              d;
    int              n;
    logic [3:0][63:0] rd;
    logic [31:0]     busy;
    logic            cb;
    logic            cd;
  } exp_t;

  exp_t sb [$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [63:0] dmask(int d);
    return (cfg_dw[d] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << cfg_dw[d]) - 64'd1);
  endfunction

  function automatic void model_reset(int d);
    for (int i = 0; i < 32; i++) begin
      m_mem[d][i]  = '0;
      m_busy[d][i] = 1'b0;
    end
    m_phase[d] = 0;
    m_idx[d]   = 0;
  endfunction

  function automatic exp_t expect_now(int d);
    exp_t e;
    logic [4:0] ra [3];
    int dep, a, wa, wb;
    logic [63:0] v;
    ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
    dep  = cfg_depth[d];
    wa   = int'(waddr_a) % dep;
    wb   = int'(waddr_b) % dep;
    e.d  = d;
    e.n  = cfg_nrd[d];
    e.cb = (m_phase[d] == 1);
    e.cd = (m_phase[d] == 2);
    e.busy = '0;
    for (int i = 0; i < dep; i++) e.busy[i] = m_busy[d][i];
    e.rd = '0;
    for (int p = 0; p < e.n; p++) begin
      a = int'(ra[p]) % dep;
      v = m_mem[d][a];
      if (cfg_byp[d] == 1 && m_phase[d] == 0 && we_b && wb == a && !(cfg_zr[d] == 1 && a == 0))
        v = wdata_b & dmask(d);
      else if (cfg_byp[d] == 1 && m_phase[d] == 0 && we_a && wa == a && !(cfg_zr[d] == 1 && a == 0))
        v = wdata_a & dmask(d);
      if (cfg_zr[d] == 1 && a == 0) v = '0;
      e.rd[p] = v;
    end
    return e;
  endfunction

  function automatic void model_edge(int d);
    int dep, wa, wb, ba;
    if (!async_reset) return;
    dep = cfg_depth[d];
    wa  = int'(waddr_a) % dep;
    wb  = int'(waddr_b) % dep;
    ba  = int'(busy_addr) % dep;
    case (m_phase[d])
      0: begin
        if (we_a && !(cfg_zr[d] == 1 && wa == 0)) m_mem[d][wa] = wdata_a & dmask(d);
        if (we_b && !(cfg_zr[d] == 1 && wb == 0)) m_mem[d][wb] = wdata_b & dmask(d);
        if (we_a) m_busy[d][wa] = 1'b0;
        if (we_b) m_busy[d][wb] = 1'b0;
        if (busy_set) m_busy[d][ba] = 1'b1;
        if (cfg_zr[d] == 1) m_busy[d][0] = 1'b0;
        if (clear_req) begin
          m_phase[d] = 1;
          m_idx[d]   = 0;
        end
      end
      1: begin
        m_mem[d][m_idx[d]]  = '0;
        m_busy[d][m_idx[d]] = 1'b0;
        if (m_idx[d] == dep - 1) m_phase[d] = 2;
        m_idx[d] = (m_idx[d] + 1) % dep;
      end
      default: m_phase[d] = 0;
    endcase
  endfunction

  function automatic logic [63:0] act_rd(int d, int p);
    case (d)
      0:       return {32'd0, rd_0[p*32 +: 32]};
      1:       return rd_1[p*64 +: 64];
      default: return {32'd0, rd_2[p*32 +: 32]};
    endcase
  endfunction

  function automatic logic [31:0] act_busy(int d);
    case (d)
      0:       return busy_0;
      1:       return {16'd0, busy_1};
      default: return busy_2;
    endcase
  endfunction

  function automatic logic act_cb(int d);
    return (d == 0) ? cb_0 : (d == 1) ? cb_1 : cb_2;
  endfunction

  function automatic logic act_cd(int d);
    return (d == 0) ? cd_0 : (d == 1) ? cd_1 : cd_2;
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  // Monitor: compares every presented expectation against the live outputs
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      for (int p = 0; p < e.n; p++) chk($sformatf("rdata%0d", p), e.d, act_rd(e.d, p), e.rd[p]);
      chk("busy", e.d, {32'd0, act_busy(e.d)}, {32'd0, e.busy});
      chk("clear_busy", e.d, {63'd0, act_cb(e.d)}, {63'd0, e.cb});
      chk("clear_done", e.d, {63'd0, act_cd(e.d)}, {63'd0, e.cd});
    end
  end

  task automatic idle_inputs();
    we_a = 1'b0; we_b = 1'b0; busy_set = 1'b0; clear_req = 1'b0;
  endtask

  task automatic step();
    for (int d = 0; d < 3; d++) begin
      if (!async_reset) model_reset(d);
      sb.push_back(expect_now(d));
    end
    @(posedge clock);
    for (int d = 0; d < 3; d++) model_edge(d);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) model_reset(d);
    async_reset = 1'b0;
    idle_inputs();
    waddr_a = '0; waddr_b = '0; busy_addr = '0;
    wdata_a = '0; wdata_b = '0;
    ra0 = 5'd0; ra1 = 5'd5; ra2 = 5'd7;
    @(posedge clock); #1;

    // reset state
    step(); step();
    async_reset = 1'b1;
    step();

    // basic write then read, including the same-cycle forwarded read
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 64'h0123_4567_DEAD_BEEF;
    ra0 = 5'd5; ra1 = 5'd0; ra2 = 5'd5;
    step();
    idle_inputs();
    step();

    // register 0 writes: dropped with a hardwired zero, kept otherwise
    we_a = 1'b1; waddr_a = 5'd0; wdata_a = 64'h1234;
    ra0 = 5'd0; ra1 = 5'd5; ra2 = 5'd0;
    step();
    idle_inputs();
    step();

    // write-port clash on register 7: B wins, forwarded read shows B
    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 64'h11;
    we_b = 1'b1; waddr_b = 5'd7; wdata_b = 64'h22;
    ra0 = 5'd7; ra1 = 5'd7; ra2 = 5'd7;
    step();
    idle_inputs();
    step();

    // scoreboard: set, clear by write, then simultaneous set + write
    busy_set = 1'b1; busy_addr = 5'd3;
    step();
    idle_inputs();
    step();
    we_a = 1'b1; waddr_a = 5'd3; wdata_a = 64'h33;
    ra0 = 5'd3;
    step();
    idle_inputs();
    step();
    busy_set = 1'b1; busy_addr = 5'd3;
    we_b = 1'b1; waddr_b = 5'd3; wdata_b = 64'h55;
    step();
    idle_inputs();
    busy_set = 1'b1; busy_addr = 5'd0;
    step();
    idle_inputs();
    step();

    // fill every register, then sweep with a write attempted mid-sweep
    for (int i = 0; i < 32; i++) begin
      we_a = 1'b1; waddr_a = 5'(i); wdata_a = {$urandom, $urandom} | 64'h1;
      busy_set = 1'b1; busy_addr = 5'((i + 7) % 32);
      ra0 = 5'($urandom_range(0, 31)); ra1 = 5'(i); ra2 = 5'($urandom_range(0, 31));
      step();
    end
    idle_inputs();
    clear_req = 1'b1;
    step();
    for (int c = 0; c < 34; c++) begin
      idle_inputs();
      if (c == 5) begin
        we_a = 1'b1; waddr_a = 5'd9; wdata_a = 64'hFF;
        we_b = 1'b1; waddr_b = 5'd20; wdata_b = 64'hEE;
        busy_set = 1'b1; busy_addr = 5'd9; clear_req = 1'b1;
        ra0 = 5'd9; ra1 = 5'd20; ra2 = 5'd9;
      end else begin
        ra0 = 5'($urandom_range(0, 31)); ra1 = 5'($urandom_range(0, 31)); ra2 = 5'($urandom_range(0, 31));
      end
      step();
    end
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'((i + 1) % 32); ra2 = 5'((i + 2) % 32);
      step();
    end

    // reset asserted at sweep cycle 10
    for (int i = 0; i < 32; i++) begin
      we_a = 1'b1; waddr_a = 5'(i); wdata_a = {$urandom, $urandom} | 64'h2;
      busy_set = 1'b1; busy_addr = 5'(i);
      step();
    end
    idle_inputs();
    clear_req = 1'b1;
    step();
    idle_inputs();
    for (int c = 0; c < 10; c++) step();
    async_reset = 1'b0;
    ra0 = 5'd4; ra1 = 5'd12; ra2 = 5'd1;
    step();
    async_reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      ra0 = 5'($urandom_range(0, 31)); ra1 = 5'($urandom_range(0, 31)); ra2 = 5'($urandom_range(0, 31));
      step();
    end

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      async_reset = ($urandom_range(0, 149) != 0);
      we_a = async_reset && ($urandom_range(0, 1) == 1);
      we_b = async_reset && ($urandom_range(0, 2) == 0);
      waddr_a = 5'($urandom_range(0, 31));
      waddr_b = ($urandom_range(0, 3) == 0) ? waddr_a : 5'($urandom_range(0, 31));
      wdata_a = {$urandom, $urandom};
      wdata_b = {$urandom, $urandom};
      busy_set = async_reset && ($urandom_range(0, 2) == 0);
      busy_addr = ($urandom_range(0, 2) == 0) ? waddr_a : 5'($urandom_range(0, 31));
      clear_req = async_reset && ($urandom_range(0, 59) == 0);
      ra0 = ($urandom_range(0, 1) == 1) ? waddr_a : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 1) == 1) ? waddr_b : 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      step();
    end
    async_reset = 1'b1;
    idle_inputs();
    step();

    @(negedge clock); #1;
    chk("scoreboard_drained", 0, 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp_param.md
REGFILE_MP_PARAM -- requirements
Module: regfile_mp_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of registers; power of two, minimum 4.
REQ-003 SHALL have parameter N_RD, default 2, meaning number of read ports, range 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding when 1.
REQ-006 SHALL derive local AW = clog2(DEPTH).
REQ-007 SHALL have port clock  in  1  rising-edge clock for all state.
REQ-008 SHALL have port async_reset  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port we_a  in  1  write-enable, port A.
REQ-010 SHALL have port waddr_a  in  AW  write address, port A.
REQ-011 SHALL have port wdata_a  in  DATA_W  write data, port A.
REQ-012 SHALL have ports we_b, waddr_b and wdata_b, identical to port A; these form port B.
REQ-013 SHALL have port raddr  in  N_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-014 SHALL have port rdata  out  N_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W].
REQ-015 SHALL have port busy_set  in  1  marks busy_addr pending (producer issued).
REQ-016 SHALL have port busy_addr  in  AW  scoreboard address to mark.
REQ-017 SHALL have port busy  out  DEPTH  per-register pending bits.
REQ-018 SHALL have port clear_req  in  1  one-cycle request to start a sweep clear.
REQ-019 SHALL have port clear_busy  out  1  high while the sweep is active.
REQ-020 SHALL have port clear_done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-021 SHALL perform writes on the rising clock edge; reads SHALL be combinational.
REQ-022 SHALL give port B priority when we_a and we_b target the same address in the same cycle; the port-A write is dropped.
REQ-023 SHALL ignore writes to address 0 and read 0 from address 0 when ZERO_REG=1; when ZERO_REG=0, register 0 is ordinary.
REQ-024 SHALL forward write data when BYPASS=1 and an enabled write targets a read address in the same cycle; port B data is forwarded when both ports match. Address 0 is never forwarded when ZERO_REG=1.
REQ-025 SHALL return the pre-edge stored value when BYPASS=0; new data is visible the cycle after the write.
REQ-026 SHALL set busy[busy_addr] on the edge when busy_set=1.
REQ-027 SHALL clear busy[n] on the edge when any enabled write targets n.
REQ-028 SHALL let set win when busy_set and a write hit the same address on the same edge.
REQ-029 SHALL hold busy[0] at 0 when ZERO_REG=1.
REQ-030 SHALL implement a sweep FSM with states IDLE, SWEEP and DONE.
- IDLE -> SWEEP on clear_req; the index counter is loaded with 0.
- SWEEP: each cycle writes 0 to reg[index] and clears busy[index], then increments index; after index = DEPTH-1 the FSM goes to DONE. The sweep lasts exactly DEPTH cycles.
- DONE: asserts clear_done for one cycle, then returns to IDLE.
REQ-031 SHALL drive clear_busy=1 exactly in SWEEP.
REQ-032 SHALL ignore we_a, we_b, busy_set and clear_req in SWEEP and DONE.
REQ-033 SHALL keep reads live during the sweep; swept registers return 0.
REQ-034 SHALL wrap the index to 0 modulo DEPTH, with no out-of-range access.

Reset
REQ-035 SHALL, on async_reset low, immediately zero all registers and busy, set the FSM to IDLE, zero the index, and drive clear_busy=0 and clear_done=0.
REQ-036 SHALL abort a sweep on reset asserted mid-sweep, with no clear_done pulse.
REQ-037 SHALL resume normal operation on the first rising edge after reset release.

Verification
REQ-038 Reset then write and read: we_a with waddr_a=5, wdata_a=0xDEADBEEF; next cycle raddr port0=5 -> rdata0=0xDEADBEEF; raddr=0 -> 0.
REQ-039 Write-port conflict: we_a and we_b both to addr 7 with A=0x11, B=0x22 -> reg7=0x22; the same-cycle bypass read of 7 returns 0x22 (BYPASS=1), or the old value with BYPASS=0.
REQ-040 Scoreboard: busy_set addr 3 -> busy[3]=1; then write addr 3 -> busy[3]=0; simultaneous set and write to 3 -> busy[3]=1 and the data is written.
REQ-041 Sweep: fill all registers with nonzero values, pulse clear_req -> clear_busy high for exactly DEPTH cycles, one clear_done pulse, all reads 0, busy all 0; a write attempted mid-sweep has no effect.
REQ-042 Reset mid-sweep: assert async_reset at sweep cycle 10 -> immediate zero outputs and IDLE, and no clear_done pulse.
REQ-043 Parameter sweep: run REQ-038 to REQ-041 with (DATA_W=64, DEPTH=16, N_RD=3, ZERO_REG=0) and confirm register 0 is writable.
